// File: rtl/sprite_rom.sv
// sprite_rom: procedural sprite pixel generator with one registered output.
//   Parameters: WIDTH, HEIGHT  - sprite extent in pixels
//               LOG_FRAMES     - bit width of the frame index
//   Ports:      vclock         - clock (rising edge)
//               reset          - asynchronous active-low reset
//               x, y           - pixel coordinate relative to sprite origin
//               s_type         - 0-3 collectable, 4 character, 5-7 unused
//               frame          - animation frame index
//               pixel          - registered RGB 4:4:4, 12'h000 = transparent
module sprite_rom #(
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 20,
  parameter int LOG_FRAMES = 3
) (
  input  logic                  vclock,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [2:0]            s_type,
  input  logic [LOG_FRAMES-1:0] frame,
  output logic [11:0]           pixel
);

  localparam int CX = WIDTH / 2;
  localparam int CY = HEIGHT / 2;
  localparam int R  = ((WIDTH < HEIGHT) ? WIDTH : HEIGHT) / 2 - 1;

  localparam logic [10:0] W11 = 11'(WIDTH);
  localparam logic [10:0] H11 = 11'(HEIGHT);
  localparam logic [13:0] CX14 = 14'(CX);
  localparam logic [13:0] CY14 = 14'(CY);
  localparam logic [13:0] R14  = 14'(R);

  logic        w_in_range;
  logic [31:0] w_frame;
  logic [11:0] w_torso;
  logic [11:0] w_char;
  logic [13:0] w_dx;
  logic [13:0] w_dy;
  logic [13:0] w_adx;
  logic [13:0] w_ady;
  logic [13:0] w_d;
  logic [11:0] w_coll;
  logic [11:0] w_pixel;
  logic [11:0] r_pixel;

  assign w_in_range = (x < W11) && (y < H11);
  assign w_frame    = 32'(frame);

  always_comb begin
    w_torso = 12'h0F0;
    case (w_frame)
      32'd1:   w_torso = 12'hFF0;
      32'd2:   w_torso = 12'hF80;
      default: w_torso = 12'h0F0;
    endcase
  end

  always_comb begin
    w_char = '0;
    if (y <= 11'd5) begin
      if (x >= 11'd6 && x <= 11'd13) w_char = 12'hFC8;
    end else if (y <= 11'd13) begin
      if (x >= 11'd4 && x <= 11'd15) w_char = w_torso;
    end else if (y <= 11'd19) begin
      if ((x >= 11'd5 && x <= 11'd8) || (x >= 11'd11 && x <= 11'd14))
        w_char = 12'h840;
    end
  end

  // Manhattan distance in 14-bit two's complement; 11-bit coordinates
  // cannot overflow it, so the absolute values and sum never wrap.
  assign w_dx  = {3'b000, x} - CX14;
  assign w_dy  = {3'b000, y} - CY14;
  assign w_adx = w_dx[13] ? (~w_dx + 14'd1) : w_dx;
  assign w_ady = w_dy[13] ? (~w_dy + 14'd1) : w_dy;
  assign w_d   = w_adx + w_ady;

  always_comb begin
    w_coll = '0;
    if (w_d <= R14) begin
      case (s_type[1:0])
        2'd0:    w_coll = 12'hFD0;
        2'd1:    w_coll = 12'h0FF;
        2'd2:    w_coll = 12'hF0F;
        default: w_coll = 12'hF88;
      endcase
      if (frame[0] && w_d <= 14'd2) w_coll = 12'hFFF;
    end
  end

  always_comb begin
    w_pixel = '0;
    if (w_in_range) begin
      if (s_type == 3'd4)      w_pixel = w_char;
      else if (s_type < 3'd4)  w_pixel = w_coll;
    end
  end

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) r_pixel <= '0;
    else        r_pixel <= w_pixel;
  end

  assign pixel = r_pixel;

endmodule

// File: tb/tb_sprite_rom.sv
module tb_sprite_rom;

  logic        vclock = 1'b0;
  logic        reset  = 1'b0;

  // Instance A: 20x20 (character checks)
  logic [10:0] xa = '0, ya = '0;
  logic [2:0]  sa = '0, fa = '0;
  logic [11:0] pa;
  // Instance B: 15x16 (collectable checks)
  logic [10:0] xb = '0, yb = '0;
  logic [2:0]  sb = '0, fb = '0;
  logic [11:0] pb;

  int n_pass  = 0;
  int n_total = 0;

  sprite_rom #(.WIDTH(20), .HEIGHT(20), .LOG_FRAMES(3)) u_a (
    .vclock(vclock), .reset(reset), .x(xa), .y(ya),
    .s_type(sa), .frame(fa), .pixel(pa)
  );

  sprite_rom #(.WIDTH(15), .HEIGHT(16), .LOG_FRAMES(3)) u_b (
    .vclock(vclock), .reset(reset), .x(xb), .y(yb),
    .s_type(sb), .frame(fb), .pixel(pb)
  );

  always #5 vclock = ~vclock;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  st;
    logic [2:0]  fr;
    logic [11:0] exp;
  } vec_t;

  task automatic step();
    @(posedge vclock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (pa !== 12'h000) $display("FAIL reset_a: got %h want 000", pa);
    else n_pass++;
    n_total++;
    if (pb !== 12'h000) $display("FAIL reset_b: got %h want 000", pb);
    else n_pass++;
    // Inputs that would be opaque must not leak through while in reset
    xa = 11'd10; ya = 11'd10; sa = 3'd4; fa = 3'd0;
    step();
    n_total++;
    if (pa !== 12'h000) $display("FAIL reset_hold: got %h want 000", pa);
    else n_pass++;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_char_frames();
    vec_t v[4];
    v = '{'{11'd10, 11'd10, 3'd4, 3'd0, 12'h0F0},
          '{11'd10, 11'd10, 3'd4, 3'd1, 12'hFF0},
          '{11'd10, 11'd10, 3'd4, 3'd2, 12'hF80},
          '{11'd10, 11'd10, 3'd4, 3'd5, 12'h0F0}};
    for (int i = 0; i < 4; i++) begin
      xa = v[i].x; ya = v[i].y; sa = v[i].st; fa = v[i].fr;
      step();
      n_total++;
      if (pa !== v[i].exp)
        $display("FAIL char_frame%0d: got %h want %h", v[i].fr, pa, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_char_regions();
    vec_t v[5];
    v = '{'{11'd8,  11'd2,  3'd4, 3'd0, 12'hFC8},
          '{11'd6,  11'd16, 3'd4, 3'd0, 12'h840},
          '{11'd9,  11'd16, 3'd4, 3'd0, 12'h000},
          '{11'd0,  11'd0,  3'd4, 3'd0, 12'h000},
          '{11'd20, 11'd5,  3'd4, 3'd0, 12'h000}};
    for (int i = 0; i < 5; i++) begin
      xa = v[i].x; ya = v[i].y; sa = v[i].st; fa = v[i].fr;
      step();
      n_total++;
      if (pa !== v[i].exp)
        $display("FAIL char_region(%0d,%0d): got %h want %h", v[i].x, v[i].y, pa, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_collectable();
    vec_t v[12];
    v = '{'{11'd7,  11'd8,  3'd1, 3'd0, 12'h0FF},
          '{11'd7,  11'd8,  3'd1, 3'd1, 12'hFFF},
          '{11'd7,  11'd2,  3'd0, 3'd1, 12'hFD0},
          '{11'd0,  11'd0,  3'd0, 3'd1, 12'h000},
          '{11'd9,  11'd8,  3'd0, 3'd1, 12'hFFF},
          '{11'd7,  11'd8,  3'd2, 3'd0, 12'hF0F},
          '{11'd7,  11'd14, 3'd3, 3'd0, 12'hF88},
          '{11'd7,  11'd15, 3'd3, 3'd0, 12'h000},
          '{11'd10, 11'd8,  3'd3, 3'd1, 12'hF88},
          '{11'd10, 11'd10, 3'd4, 3'd0, 12'h0F0},
          '{11'd7,  11'd8,  3'd5, 3'd0, 12'h000},
          '{11'd15, 11'd8,  3'd1, 3'd0, 12'h000}};
    for (int i = 0; i < 12; i++) begin
      xb = v[i].x; yb = v[i].y; sb = v[i].st; fb = v[i].fr;
      step();
      n_total++;
      if (pb !== v[i].exp)
        $display("FAIL coll_%0d(%0d,%0d,t%0d,f%0d): got %h want %h",
                 i, v[i].x, v[i].y, v[i].st, v[i].fr, pb, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_invalid_type();
    vec_t v[3];
    v = '{'{11'd10, 11'd10, 3'd6, 3'd0, 12'h000},
          '{11'd8,  11'd2,  3'd6, 3'd1, 12'h000},
          '{11'd10, 11'd10, 3'd7, 3'd0, 12'h000}};
    for (int i = 0; i < 3; i++) begin
      xa = v[i].x; ya = v[i].y; sa = v[i].st; fa = v[i].fr;
      step();
      n_total++;
      if (pa !== v[i].exp) $display("FAIL invalid_type%0d: got %h want 000", i, pa);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[9];
    v = '{'{11'd4,  11'd6,  3'd4, 3'd1, 12'hFF0},
          '{11'd15, 11'd13, 3'd4, 3'd2, 12'hF80},
          '{11'd16, 11'd13, 3'd4, 3'd2, 12'h000},
          '{11'd13, 11'd5,  3'd4, 3'd0, 12'hFC8},
          '{11'd14, 11'd19, 3'd4, 3'd0, 12'h840},
          '{11'd10, 11'd14, 3'd4, 3'd0, 12'h000},
          '{11'd11, 11'd14, 3'd4, 3'd0, 12'h840},
          '{11'd10, 11'd20, 3'd4, 3'd0, 12'h000},
          '{11'd3,  11'd6,  3'd4, 3'd0, 12'h000}};
    for (int i = 0; i < 9; i++) begin
      xa = v[i].x; ya = v[i].y; sa = v[i].st; fa = v[i].fr;
      // Output must still reflect the previous vector before the edge
      if (i > 0) begin
        #2;
        n_total++;
        if (pa !== v[i-1].exp)
          $display("FAIL b2b_hold%0d: got %h want %h", i, pa, v[i-1].exp);
        else n_pass++;
      end
      step();
      n_total++;
      if (pa !== v[i].exp)
        $display("FAIL b2b_%0d(%0d,%0d): got %h want %h", i, v[i].x, v[i].y, pa, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    xa = 11'd10; ya = 11'd10; sa = 3'd4; fa = 3'd0;
    step();
    n_total++;
    if (pa !== 12'h0F0) $display("FAIL areset_pre: got %h want 0F0", pa);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if (pa !== 12'h000) $display("FAIL areset_immediate: got %h want 000", pa);
    else n_pass++;
    step();
    n_total++;
    if (pa !== 12'h000) $display("FAIL areset_held: got %h want 000", pa);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (pa !== 12'h000) $display("FAIL areset_release: got %h want 000", pa);
    else n_pass++;
    step();
    n_total++;
    if (pa !== 12'h0F0) $display("FAIL areset_first_edge: got %h want 0F0", pa);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_char_frames();
    test_char_regions();
    test_collectable();
    test_invalid_type();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sprite_rom.md
SPRITE_ROM -- requirements
Module: sprite_rom

Interface
REQ-001 Parameter WIDTH, default 20: sprite width in pixels; valid x range is 0..WIDTH-1.
REQ-002 Parameter HEIGHT, default 20: sprite height in pixels; valid y range is 0..HEIGHT-1.
REQ-003 Parameter LOG_FRAMES, default 3: bit width of the frame input.
REQ-004 Port vclock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port x, input, 11: pixel column relative to the sprite origin.
REQ-007 Port y, input, 11: pixel row relative to the sprite origin.
REQ-008 Port s_type, input, 3: sprite type; 0-3 are collectables, 4 is the character, 5-7 are unused.
REQ-009 Port frame, input, LOG_FRAMES: animation frame index.
REQ-010 Port pixel, output, 12 (registered): RGB 4:4:4 colour; 12'h000 means transparent.

Function
REQ-011 pixel SHALL update on each rising edge of vclock from the current inputs, giving exactly 1 cycle of latency; there is no handshake.
REQ-012 If x >= WIDTH, or y >= HEIGHT, or s_type is 5-7, pixel SHALL become 12'h000.
REQ-013 Character (s_type=4): regions use absolute coordinates, clipped by REQ-012; rows are y, columns are x, and all bounds are inclusive.
REQ-014 Character head: rows 0-5, columns 6-13 SHALL give 12'hFC8.
REQ-015 Character torso: rows 6-13, columns 4-15 SHALL give the frame colour.
- frame 0: 12'h0F0
- frame 1 (rising): 12'hFF0
- frame 2 (falling): 12'hF80
- frame 3 and above: treated as frame 0
REQ-016 Character legs: rows 14-19, columns 5-8 or 11-14 SHALL give 12'h840.
REQ-017 Any other character pixel SHALL be 12'h000.
REQ-018 Collectable geometry: cx = WIDTH/2 and cy = HEIGHT/2 (integer division); r = min(WIDTH,HEIGHT)/2 - 1; d = |x-cx| + |y-cy|, computed signed with at least 12 bits so there is no wrap.
REQ-019 Collectable with d > r SHALL give 12'h000.
REQ-020 Collectable with d <= r SHALL give the type colour: type 0 = 12'hFD0, type 1 = 12'h0FF, type 2 = 12'hF0F, type 3 = 12'hF88.
REQ-021 Collectable sparkle: when frame[0]=1 and d <= 2, pixel SHALL be 12'hFFF, overriding REQ-020.
REQ-022 An opaque pixel SHALL never be 12'h000.
REQ-023 Output SHALL depend only on the inputs sampled at the previous edge; there is no other internal state.
REQ-024 Inputs that change every cycle SHALL produce a correct pixel for each cycle's inputs, one cycle later.

Reset
REQ-025 While reset=0, pixel SHALL be 12'h000 immediately, without waiting for a clock edge.
REQ-026 Reset asserted mid-stream SHALL clear pixel to 12'h000 asynchronously.
REQ-027 After reset deasserts, the first rising edge SHALL produce the normal lookup result.

Verification
REQ-028 Character, WIDTH=20, HEIGHT=20, s_type=4, x=10, y=10, frame 0 -> 12'h0F0; frame 1 -> 12'hFF0; frame 2 -> 12'hF80; frame 5 -> 12'h0F0; each one cycle after the inputs are applied.
REQ-029 Character regions, s_type=4: (8,2) -> 12'hFC8; (6,16) -> 12'h840; (9,16) -> 12'h000; (0,0) -> 12'h000; (20,5) -> 12'h000 (out of range).
REQ-030 Collectable, WIDTH=15, HEIGHT=16, s_type=1, x=7, y=8: frame 0 -> 12'h0FF; frame 1 -> 12'hFFF.
REQ-031 Same collectable parameters, s_type=0, frame 1: (7,2) -> 12'hFD0 (d=6); (0,0) -> 12'h000 (d=15); (9,8) -> 12'hFFF (d=2).
REQ-032 s_type=6 at any coordinate -> 12'h000.
REQ-033 Pulse reset low between clock edges while pixel is non-zero -> pixel reads 12'h000 before the next edge and stays 12'h000 until the first edge after release.
